// File: rtl/vend_credit_ctrl.sv
// Coin-credit controller: accumulates coin credit, strobes a vend at PRICE,
// then returns overpayment or refunds one coin per ready cycle.
module vend_credit_ctrl #(
    parameter int unsigned PRICE    = 100,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic                cancel,
    input  logic                change_ready,
    output logic                valid,
    output logic [2:0]          change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int unsigned TOTAL_W = CREDIT_W + 1;

    localparam logic [0:0] ACCUM  = 1'b0;
    localparam logic [0:0] CHANGE = 1'b1;

    localparam logic [TOTAL_W-1:0]  NICKEL_T  = TOTAL_W'(5);
    localparam logic [TOTAL_W-1:0]  DIME_T    = TOTAL_W'(10);
    localparam logic [TOTAL_W-1:0]  QUARTER_T = TOTAL_W'(25);
    localparam logic [TOTAL_W-1:0]  PRICE_T   = TOTAL_W'(PRICE);

    localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);

    // Change coin encodings, {nickel, dime, quarter}
    localparam logic [2:0] CH_NICKEL  = 3'b100;
    localparam logic [2:0] CH_DIME    = 3'b010;
    localparam logic [2:0] CH_QUARTER = 3'b001;

    logic [0:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                valid_q, valid_d;
    logic [2:0]          change_q, change_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic                any_coin;
    logic [TOTAL_W-1:0]  coin_sum;
    logic [TOTAL_W-1:0]  total;
    logic [TOTAL_W-1:0]  remainder;
    logic [CREDIT_W-1:0] coin_val;
    logic [2:0]          coin_sel;
    logic [CREDIT_W-1:0] credit_left;

    // Coin arithmetic carried one bit wider so the PRICE compare cannot wrap
    always_comb begin
        any_coin  = nickel | dime | quarter;
        coin_sum  = (nickel  ? NICKEL_T  : '0)
                  + (dime    ? DIME_T    : '0)
                  + (quarter ? QUARTER_T : '0);
        total     = {1'b0, credit_q} + coin_sum;
        remainder = total - PRICE_T;
    end

    // Greedy largest-coin-first selection for change/refund
    always_comb begin
        coin_val = NICKEL_C;
        coin_sel = CH_NICKEL;
        if (credit_q >= QUARTER_C) begin
            coin_val = QUARTER_C;
            coin_sel = CH_QUARTER;
        end else if (credit_q >= DIME_C) begin
            coin_val = DIME_C;
            coin_sel = CH_DIME;
        end
        credit_left = credit_q - coin_val;
    end

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        valid_d       = 1'b0;
        change_d      = 3'b000;
        coin_reject_d = 1'b0;

        case (state_q)
            ACCUM: begin
                if (cancel) begin
                    coin_reject_d = any_coin;
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                    end
                end else if (total >= PRICE_T) begin
                    valid_d  = 1'b1;
                    credit_d = CREDIT_W'(remainder);
                    if (remainder != '0) begin
                        state_d = CHANGE;
                    end
                end else begin
                    credit_d = CREDIT_W'(total);
                end
            end
            CHANGE: begin
                coin_reject_d = any_coin;
                if (change_ready) begin
                    change_d = coin_sel;
                    credit_d = credit_left;
                    if (credit_left == '0) begin
                        state_d = ACCUM;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        busy_d = (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ACCUM;
            credit_q      <= '0;
            valid_q       <= 1'b0;
            change_q      <= 3'b000;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            valid_q       <= valid_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    assign valid       = valid_q;
    assign change      = change_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Parametrised coin-credit controller for the vending machine datapath. It accumulates nickel, dime and quarter credit, including simultaneous coins, and pulses `valid` once credit reaches a configurable price. It then returns any overpayment as change, one coin at a time, through a ready-gated dispenser handshake, and supports a customer cancel/refund. It sits between the coin-acceptor synchroniser and the product/change dispenser drivers.

## Interface
- `PRICE`, default 100: vend price in cents; a multiple of 5, range 5..(2**CREDIT_W − 40).
- `CREDIT_W`, default 8: credit register width; must satisfy PRICE + 35 < 2**CREDIT_W.
- `clk` input, 1 bit: system clock, all logic on posedge.
- `reset_n` input, 1 bit: reset, asynchronous, active-low.
- `nickel` input, 1 bit: 5¢ coin accepted, single-cycle pulse, synchronous to clk.
- `dime` input, 1 bit: 10¢ coin accepted, single-cycle pulse.
- `quarter` input, 1 bit: 25¢ coin accepted, single-cycle pulse.
- `cancel` input, 1 bit: refund request, single-cycle pulse.
- `change_ready` input, 1 bit: dispenser can take one coin this cycle.
- `valid` output, 1 bit: vend strobe, high exactly one cycle per sale.
- `change` output, 3 bits: {nickel, dime, quarter} coin to eject; one-hot or zero; one-cycle pulse.
- `coin_reject` output, 1 bit: coins presented this cycle were not credited; route them to the return chute.
- `credit` output, CREDIT_W bits: current credit in cents.
- `busy` output, 1 bit: high while in CHANGE.

## Operation
- FSM has two states, ACCUM and CHANGE. All outputs are registered.
- Reset state: ACCUM, `credit`=0, `valid`=0, `change`=0, `coin_reject`=0, `busy`=0.
- In ACCUM, let coin_sum = 5·nickel + 10·dime + 25·quarter, range 0..40, and total = credit + coin_sum. Compute total at CREDIT_W+1 bits.
  - cancel=1: cancel has priority.
    - If any coin is also present, set `coin_reject`=1 for one cycle.
    - If credit>0, go to CHANGE with credit unchanged.
    - If credit=0, do nothing.
  - total ≥ PRICE:
    - `valid`=1 for one cycle.
    - credit ← total − PRICE.
    - If the remainder is greater than 0, go to CHANGE; otherwise stay in ACCUM.
  - Otherwise: credit ← total.
- In CHANGE (`busy`=1):
  - Any coin present sets `coin_reject`=1 for that cycle. cancel is ignored.
  - On each edge with change_ready=1, select a coin greedily: quarter if credit ≥ 25, else dime if credit ≥ 10, else nickel.
    - `change` ← one-hot of the selected coin.
    - credit ← credit − coin value.
    - If the new credit is 0, go to ACCUM.
  - change_ready=0: `change`=0 and credit holds.
- `valid`, `change` and `coin_reject` are 0 on every edge that does not set them.
- Credit is always a multiple of 5. In ACCUM it stays below PRICE, so the width can never overflow.

## Timing
- Coin sampled at edge N: `credit`, `valid` and the state update at edge N. `valid` is high from N to N+1. Latency is 1 clk.
- The first change coin can appear at edge N+1 at the earliest. After that, coins dispense at one per cycle while change_ready is held high.
- Refund time is ceil-greedy: at most ⌈credit/25⌉ + 2 ready cycles.
- `busy` falls on the same edge that the last `change` pulse is asserted.
- A coin arriving on the edge that returns the FSM to ACCUM is rejected, because it is sampled in CHANGE. The next edge accepts coins.
- Reset asserted mid-CHANGE clears all state immediately; undispensed change is lost by design, and the credit value is lost too.
- Simultaneous coins in one cycle are summed, not serialised.

## Test plan
- Four quarters on separate edges, PRICE=100 → `valid` one cycle on the 4th-coin edge, `credit`=0, no `change`, `busy` stays 0.
- Three quarters, then dime and quarter on the same edge, change_ready=1 → `valid` on that edge, `credit`=10, then `change`=3'b010 on the next edge and `credit`=0.
- Credit 65 then cancel, change_ready=1 → `change` sequence quarter, quarter, dime, nickel on 4 consecutive edges; `credit` goes 40/15/5/0; no `valid`.
- Same as the previous case with change_ready low for 3 cycles mid-refund → `change`=0 and `credit` held during the stall; the sequence resumes unchanged.
- Nickel during CHANGE, and dime together with cancel in ACCUM → `coin_reject` one cycle each time; `credit` unaffected by those coins.
- Assert reset_n low mid-refund at credit 40 → all outputs 0 asynchronously, state ACCUM; a quarter after release gives `credit`=25.
